// File: rtl/noc_flit_vc_mux.sv
// noc_flit_vc_mux: packet-atomic round-robin merge of flit streams with orphan drop and counting
module noc_flit_vc_mux #(
   parameter int CHANNELS = 2,
   parameter int DATA_WIDTH = 64,
   parameter int COUNT_WIDTH = 8,
   localparam int FLIT_WIDTH = DATA_WIDTH + 2,
   localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [CHANNELS-1:0]            i_flit_valid,
   output logic [CHANNELS-1:0]            i_flit_ready,
   input  logic [CHANNELS*FLIT_WIDTH-1:0] i_flit,
   output logic                           o_flit_valid,
   input  logic                           o_flit_ready,
   output logic [FLIT_WIDTH-1:0]          o_flit,
   output logic [CH_W-1:0]                o_channel,
   output logic                           o_drop,
   output logic [COUNT_WIDTH-1:0]         o_drop_count
);
   logic lock, any_valid, load_en, accept, orphan, hdr, tail;
   logic [CH_W-1:0] lock_ch, last_grant, grant, idx;
   logic [FLIT_WIDTH-1:0] flit;
   // Offsets are scanned from farthest to nearest so the nearest valid channel wins
   always_comb begin
      grant = lock_ch;
      idx = '0;
      if (!lock)
         for (int i = CHANNELS; i >= 1; i--) begin
            idx = CH_W'((int'(last_grant) + i) % CHANNELS);
            grant = i_flit_valid[idx] ? idx : grant;
         end
   end
   always_comb begin
      any_valid = |i_flit_valid;
      load_en = ~o_flit_valid | o_flit_ready;
      flit = i_flit[int'(grant)*FLIT_WIDTH +: FLIT_WIDTH];
      hdr = ~flit[FLIT_WIDTH-1];
      tail = flit[FLIT_WIDTH-2];
      accept = ~rst & load_en & i_flit_valid[grant];
      orphan = accept & ~hdr & ~lock;
      i_flit_ready = CHANNELS'(~rst & load_en & any_valid) << grant;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         lock <= 1'b0;
         lock_ch <= '0;
         last_grant <= CH_W'(CHANNELS - 1);
         o_flit_valid <= 1'b0;
         o_flit <= '0;
         o_channel <= '0;
         o_drop <= 1'b0;
         o_drop_count <= '0;
      end else begin
         o_drop <= orphan;
         if (orphan && o_drop_count != '1) o_drop_count <= o_drop_count + 1'b1;
         if (accept && (hdr || orphan)) last_grant <= grant;
         if (accept && hdr && !lock && !tail) begin
            lock <= 1'b1;
            lock_ch <= grant;
         end
         if (accept && !hdr && tail && lock) lock <= 1'b0;
         if (load_en) o_flit_valid <= accept & ~orphan;
         if (accept && !orphan) begin
            o_flit <= flit;
            o_channel <= grant;
         end
      end
   end
endmodule

// File: tb/tb_noc_flit_vc_mux.sv
// tb_noc_flit_vc_mux: directed scenarios plus random traffic against a packet-level reference model
module tb_noc_flit_vc_mux;
   localparam int N = 2, DW = 16, CW = 8, FW = DW + 2;
   logic clk = 1'b0, rst;
   logic [N-1:0] i_flit_valid, i_flit_ready;
   logic [N*FW-1:0] i_flit;
   logic o_flit_valid, o_flit_ready, o_drop;
   logic [FW-1:0] o_flit;
   logic [0:0] o_channel;
   logic [CW-1:0] o_drop_count;
   always #5 clk = ~clk;
   noc_flit_vc_mux #(.CHANNELS(N), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .i_flit_valid(i_flit_valid), .i_flit_ready(i_flit_ready),
      .i_flit(i_flit), .o_flit_valid(o_flit_valid), .o_flit_ready(o_flit_ready),
      .o_flit(o_flit), .o_channel(o_channel), .o_drop(o_drop), .o_drop_count(o_drop_count)
   );
   int vectors = 0, miscompares = 0;
   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   logic [FW-1:0] src [N][$];
   bit shown [N];
   int gap_pct = 0;
   int ch_log[$];
   logic [FW-1:0] fl_log[$];
   // model: packet owner, round-robin pointer, one-entry output slot, drop counter
   bit m_lock, m_ov, m_drop;
   int m_owner, m_last, m_och, m_cnt;
   logic [FW-1:0] m_of;
   function automatic logic [FW-1:0] mk(bit pay, bit tl, logic [DW-1:0] d);
      return {pay, tl, d};
   endfunction
   function automatic int m_grant();
      if (m_lock) return m_owner;
      for (int k = 1; k <= N; k++)
         if (i_flit_valid[(m_last + k) % N]) return (m_last + k) % N;
      return -1;
   endfunction
   function automatic int m_ready();
      int g = m_grant();
      if (rst || i_flit_valid == '0 || g < 0 || (m_ov && !o_flit_ready)) return 0;
      return 1 << g;
   endfunction
   task automatic m_step();
      int g = m_grant();
      bit load = !m_ov || o_flit_ready;
      bit acc, pay, tl, orph;
      logic [FW-1:0] f;
      if (rst) begin
         m_lock = 0; m_owner = 0; m_last = N - 1; m_ov = 0; m_of = '0; m_och = 0; m_drop = 0; m_cnt = 0;
         return;
      end
      acc = g >= 0 && load && i_flit_valid[g];
      f = acc ? src[g][0] : '0;
      pay = f[FW-1];
      tl = f[FW-2];
      orph = acc && pay && !m_lock;
      m_drop = orph;
      if (orph) begin
         m_cnt = m_cnt < (1 << CW) - 1 ? m_cnt + 1 : m_cnt;
         m_last = g;
      end else if (acc && !pay) begin
         m_last = g;
         if (!m_lock && !tl) begin m_lock = 1; m_owner = g; end
      end else if (acc && pay && tl) m_lock = 0;
      if (load) m_ov = acc && !orph;
      if (acc && !orph) begin m_of = f; m_och = g; end
      if (acc) begin
         void'(src[g].pop_front());
         shown[g] = 0;
      end
   endtask
   task automatic step();
      for (int c = 0; c < N; c++) begin
         if (!shown[c] && src[c].size() > 0 && $urandom_range(99) >= gap_pct) shown[c] = 1;
         i_flit_valid[c] = shown[c];
         i_flit[c*FW +: FW] = shown[c] ? src[c][0] : '0;
      end
      #1;
      check("ready", i_flit_ready, m_ready());
      if (o_flit_valid && o_flit_ready) begin
         ch_log.push_back(int'(o_channel));
         fl_log.push_back(o_flit);
      end
      @(posedge clk);
      m_step();
      #1;
      check("o_valid", o_flit_valid, m_ov);
      check("o_drop", o_drop, m_drop);
      check("drop_count", o_drop_count, m_cnt);
      if (m_ov) begin
         check("o_flit", o_flit, m_of);
         check("o_channel", o_channel, m_och);
      end
   endtask
   task automatic push3(int c, int base);
      src[c].push_back(mk(0, 0, DW'(base)));
      src[c].push_back(mk(1, 0, DW'(base + 1)));
      src[c].push_back(mk(1, 1, DW'(base + 2)));
   endtask
   task automatic push_pkt(int c, int len);
      for (int i = 0; i < len; i++) src[c].push_back(mk(i != 0, i == len - 1, DW'($urandom)));
   endtask
   task automatic clear_log();
      ch_log.delete();
      fl_log.delete();
   endtask
   task automatic check_pkts(string tag, int b0, int b1);
      check({tag, "_n"}, fl_log.size(), 6);
      for (int i = 0; i < 6 && i < fl_log.size(); i++) begin
         check({tag, "_ch"}, ch_log[i], i / 3);
         check({tag, "_data"}, fl_log[i], mk(i % 3 != 0, i % 3 == 2, DW'((i < 3 ? b0 : b1) + i % 3)));
      end
   endtask
   initial begin
      logic [FW-1:0] saved;
      rst = 1; o_flit_ready = 1; i_flit_valid = '0; i_flit = '0;
      push3(0, 'h10);
      push3(1, 'h20);
      step(); step();
      check("rst_valid", o_flit_valid, 0);
      check("rst_flit", o_flit, 0);
      check("rst_chan", o_channel, 0);
      check("rst_drop", o_drop, 0);
      check("rst_count", o_drop_count, 0);
      rst = 0; clear_log();
      repeat (8) step();
      check_pkts("atomic", 'h10, 'h20);
      clear_log();
      for (int k = 0; k < 4; k++) for (int c = 0; c < N; c++) src[c].push_back(mk(0, 1, DW'(k * 2 + c)));
      repeat (10) step();
      check("single_n", ch_log.size(), 8);
      for (int i = 0; i < ch_log.size(); i++) check("single_alt", ch_log[i], i % 2);
      clear_log();
      push3(0, 'h40);
      push3(1, 'h50);
      step(); step();
      o_flit_ready = 0;
      saved = o_flit;
      repeat (5) begin
         step();
         check("bp_stable", o_flit, saved);
         check("bp_ready", i_flit_ready, 0);
      end
      o_flit_ready = 1;
      repeat (8) step();
      check_pkts("bp", 'h40, 'h50);
      rst = 1; step(); rst = 0;
      clear_log();
      src[1].push_back(mk(1, 1, 'h77));
      step();
      check("orphan_pulse", o_drop, 1);
      check("orphan_count", o_drop_count, 1);
      step();
      check("orphan_pulse_end", o_drop, 0);
      check("orphan_fwd", fl_log.size(), 0);
      repeat (299) src[1].push_back(mk(1, 1, 'h78));
      repeat (305) step();
      check("sat_count", o_drop_count, 255);
      rst = 1; step(); rst = 0;
      src[0].push_back(mk(0, 0, 'h90));
      repeat (3) src[0].push_back(mk(1, 0, 'h91));
      src[0][3] = mk(1, 1, 'h93);
      step();
      rst = 1; step(); rst = 0;
      check("midrst_idle", o_flit_valid, 0);
      clear_log();
      repeat (5) step();
      check("midrst_drops", o_drop_count, 3);
      check("midrst_fwd", fl_log.size(), 0);
      src[0].push_back(mk(0, 1, 'hA0));
      repeat (3) step();
      check("midrst_next_n", fl_log.size(), 1);
      if (fl_log.size() > 0) check("midrst_next", fl_log[0], mk(0, 1, 'hA0));
      rst = 1; step(); rst = 0;
      gap_pct = 30;
      repeat (3000) begin
         o_flit_ready = $urandom_range(3) != 0;
         for (int c = 0; c < N; c++)
            if (src[c].size() < 4) begin
               if ($urandom_range(15) == 0) src[c].push_back(mk(1, $urandom_range(1), DW'($urandom)));
               else push_pkt(c, $urandom_range(1, 4));
            end
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
